// File: rtl/active_list.sv
// In-order retirement buffer: allocates entries at dispatch, records completions, retires in order and recovers on mispredict.
// Optional macro ACTIVE_LIST_COMPLETE_BYPASS_EN lets a completion to the head commit at the same edge.
module active_list #(
  parameter int DEPTH  = 32,
  parameter int PREG_W = 6,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_valid,
  output logic              alloc_ready,
  output logic [IDX_W-1:0]  alloc_index,
  input  logic              alloc_uses_rw,
  input  logic [4:0]        alloc_arch_rd,
  input  logic [PREG_W-1:0] alloc_new_preg,
  input  logic [PREG_W-1:0] alloc_old_preg,
  input  logic              alloc_is_branch,
  input  logic              complete_valid,
  input  logic [IDX_W-1:0]  complete_index,
  input  logic              complete_mispredict,
  output logic              commit_valid,
  output logic [4:0]        commit_arch_rd,
  output logic [PREG_W-1:0] commit_new_preg,
  output logic [PREG_W-1:0] commit_free_preg,
  output logic              commit_uses_rw,
  output logic              flush,
  output logic [DEPTH-1:0]  squash_mask,
  output logic              squash_free_valid,
  output logic [PREG_W-1:0] squash_free_preg,
  output logic [IDX_W:0]    count
);

  localparam logic [0:0]     S_RUN     = 1'b0;
  localparam logic [0:0]     S_RECOVER = 1'b1;
  localparam logic [IDX_W:0] FULL      = (IDX_W+1)'(DEPTH);

  logic [0:0]        r_state;
  logic [IDX_W-1:0]  r_head, r_tail, r_walk;
  logic [IDX_W:0]    r_count;
  logic [DEPTH-1:0]  r_valid, r_done, r_misp, r_uses_rw, r_is_branch;
  logic [4:0]        r_arch_rd  [DEPTH];
  logic [PREG_W-1:0] r_new_preg [DEPTH];
  logic [PREG_W-1:0] r_old_preg [DEPTH];

  logic              w_run, w_cpl_ok, w_head_done, w_head_misp, w_commit, w_flush, w_alloc;
  logic              w_squashed, w_walk_end, w_visit_en;
  logic [IDX_W-1:0]  w_head_nx, w_tail_m1, w_tail_m2, w_visit;
`ifdef ACTIVE_LIST_COMPLETE_BYPASS_EN
  logic              w_cpl_head;
`endif

  // Commit decision, allocation handshake and recovery-walk selection.
  always_comb begin
    w_run    = (r_state == S_RUN);
    w_cpl_ok = w_run && complete_valid && r_valid[complete_index];
`ifdef ACTIVE_LIST_COMPLETE_BYPASS_EN
    w_cpl_head  = w_cpl_ok && (complete_index == r_head);
    w_head_done = r_done[r_head] | w_cpl_head;
    w_head_misp = r_misp[r_head] | (w_cpl_head & complete_mispredict & r_is_branch[r_head]);
`else
    w_head_done = r_done[r_head];
    w_head_misp = r_misp[r_head];
`endif
    w_commit  = w_run && r_valid[r_head] && w_head_done;
    w_flush   = w_commit && w_head_misp;
    // A mispredict commit rewinds tail, so a same-edge allocation would be lost.
    alloc_ready = w_run && (r_count < FULL) && !w_flush;
    w_alloc     = alloc_valid && alloc_ready;
    alloc_index = r_tail;
    w_head_nx   = r_head + IDX_W'(1);
    w_tail_m1   = r_tail - IDX_W'(1);
    w_tail_m2   = r_tail - IDX_W'(2);
    w_squashed  = (r_count > (IDX_W+1)'(1));
    // The youngest squashed entry is visited on the flush edge itself.
    w_visit     = w_run ? w_tail_m1 : r_walk;
    w_walk_end  = w_run ? (w_tail_m1 == w_head_nx) : (r_walk == r_head);
    w_visit_en  = w_run ? (w_flush && w_squashed) : 1'b1;
  end

  // Per-entry status bits: allocate, complete, retire and squash-clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= {DEPTH{1'b0}};
      r_done  <= {DEPTH{1'b0}};
      r_misp  <= {DEPTH{1'b0}};
    end else begin
      if (w_cpl_ok) begin
        r_done[complete_index] <= 1'b1;
        r_misp[complete_index] <= complete_mispredict & r_is_branch[complete_index];
      end
      if (w_commit) begin
        r_valid[r_head] <= 1'b0;
        r_done[r_head]  <= 1'b0;
        r_misp[r_head]  <= 1'b0;
      end
      if (w_visit_en) begin
        r_valid[w_visit] <= 1'b0;
        r_done[w_visit]  <= 1'b0;
        r_misp[w_visit]  <= 1'b0;
      end
      if (w_alloc) begin
        r_valid[r_tail] <= 1'b1;
        r_done[r_tail]  <= 1'b0;
        r_misp[r_tail]  <= 1'b0;
      end
    end
  end

  // Instruction payload, written once at allocation.
  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_uses_rw[r_tail]   <= alloc_uses_rw;
      r_is_branch[r_tail] <= alloc_is_branch;
      r_arch_rd[r_tail]   <= alloc_arch_rd;
      r_new_preg[r_tail]  <= alloc_new_preg;
      r_old_preg[r_tail]  <= alloc_old_preg;
    end
  end

  // Pointers, occupancy and RUN/RECOVER sequencing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_RUN;
      r_head  <= {IDX_W{1'b0}};
      r_tail  <= {IDX_W{1'b0}};
      r_walk  <= {IDX_W{1'b0}};
      r_count <= {(IDX_W+1){1'b0}};
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_commit) r_head <= w_head_nx;
          if (w_flush) begin
            r_tail  <= w_head_nx;
            r_count <= {(IDX_W+1){1'b0}};
            if (w_squashed && !w_walk_end) begin
              r_state <= S_RECOVER;
              r_walk  <= w_tail_m2;
            end
          end else begin
            if (w_alloc) r_tail <= r_tail + IDX_W'(1);
            if (w_alloc && !w_commit) r_count <= r_count + (IDX_W+1)'(1);
            else if (!w_alloc && w_commit) r_count <= r_count - (IDX_W+1)'(1);
          end
        end
        S_RECOVER: begin
          if (w_walk_end) r_state <= S_RUN;
          else r_walk <= r_walk - IDX_W'(1);
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

  // Registered retirement, flush and free-list return pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      commit_valid      <= 1'b0;
      commit_arch_rd    <= 5'd0;
      commit_new_preg   <= {PREG_W{1'b0}};
      commit_free_preg  <= {PREG_W{1'b0}};
      commit_uses_rw    <= 1'b0;
      flush             <= 1'b0;
      squash_mask       <= {DEPTH{1'b0}};
      squash_free_valid <= 1'b0;
      squash_free_preg  <= {PREG_W{1'b0}};
    end else begin
      commit_valid      <= w_commit;
      commit_arch_rd    <= w_commit ? r_arch_rd[r_head]  : 5'd0;
      commit_new_preg   <= w_commit ? r_new_preg[r_head] : {PREG_W{1'b0}};
      commit_free_preg  <= w_commit ? r_old_preg[r_head] : {PREG_W{1'b0}};
      commit_uses_rw    <= w_commit & r_uses_rw[r_head];
      flush             <= w_flush;
      squash_mask       <= w_flush ? (r_valid & ~({{(DEPTH-1){1'b0}}, 1'b1} << r_head)) : {DEPTH{1'b0}};
      squash_free_valid <= w_visit_en & r_uses_rw[w_visit];
      squash_free_preg  <= (w_visit_en & r_uses_rw[w_visit]) ? r_new_preg[w_visit] : {PREG_W{1'b0}};
    end
  end

  assign count = r_count;

endmodule
